// File: rtl/sync_count_checker_if.sv
// sync_count_checker_if
//   Connects a counter-under-test (plus any scoreboard) to the
//   sync_count_checker monitor.
//   master : drives q_in / q_valid / clr_err and observes the status
//   slave  : the checker, which consumes samples and drives the status
//   Signals:
//     q_in       counter value under check
//     q_valid    q_in is sampled on this cycle when high
//     clr_err    synchronous clear of err_count
//     locked     sequence is tracked and correct
//     err_pulse  one-cycle pulse on a sequence break while locked
//     wrap_pulse one-cycle pulse on a correct max->0 step while locked
//     err_count  saturating count of err_pulse events
//     state      FSM state (00 IDLE, 01 SYNC, 10 LOCKED)
interface sync_count_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] q_in;
    logic             q_valid;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output q_in, q_valid, clr_err,
        input  locked, err_pulse, wrap_pulse, err_count, state
    );

    modport slave (
        input  q_in, q_valid, clr_err,
        output locked, err_pulse, wrap_pulse, err_count, state
    );
endinterface

// File: rtl/sync_count_checker.sv
// sync_count_checker
//   Monitors a WIDTH-bit up-counter. On every valid sample it checks that
//   the value is the previous sample plus one (mod 2^WIDTH). After LOCK_N
//   consecutive correct steps it locks, then flags every break (err_pulse)
//   and every correct max->0 step (wrap_pulse). Breaks while locked are
//   counted in a saturating err_count.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    sync_count_checker_if.slave (samples in, status out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no sample seen since reset; first valid sample sets base
//   SYNC   | counting consecutive correct steps towards LOCK_N
//   LOCKED | sequence tracked; breaks and wraps are reported
//   (11)   | unreachable; recovers to IDLE on the next edge
module sync_count_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sync_count_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    // Must hold the value LOCK_N itself, since the increment is compared to it.
    localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_N);

    state_t           state_q;
    logic [WIDTH-1:0] expected_q;
    logic [MW-1:0]    match_cnt_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_pulse_q;
    logic [ERR_W-1:0] err_count_q;

    logic [WIDTH-1:0] expected_d;
    logic [MW-1:0]    match_cnt_d;
    logic             is_match;
    logic             err_inc;

    always_comb begin
        expected_d  = bus.q_in + WIDTH'(1);
        match_cnt_d = match_cnt_q + MW'(1);
        is_match    = (bus.q_in == expected_q);
        err_inc     = bus.q_valid && (state_q == ST_LOCKED) && !is_match;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            expected_q   <= '0;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;

            // The base follows every valid sample, good or bad, so a break
            // re-anchors tracking on the offending value.
            if (bus.q_valid) begin
                expected_q <= expected_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.q_valid) begin
                        state_q     <= ST_SYNC;
                        match_cnt_q <= '0;
                    end
                end
                ST_SYNC: begin
                    if (bus.q_valid) begin
                        if (!is_match) begin
                            match_cnt_q <= '0;
                        end else if (match_cnt_d == LOCK_V) begin
                            state_q     <= ST_LOCKED;
                            locked_q    <= 1'b1;
                            match_cnt_q <= '0;
                        end else begin
                            match_cnt_q <= match_cnt_d;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.q_valid) begin
                        if (is_match) begin
                            wrap_pulse_q <= (bus.q_in == '0);
                        end else begin
                            err_pulse_q <= 1'b1;
                            locked_q    <= 1'b0;
                            state_q     <= ST_SYNC;
                            match_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    locked_q    <= 1'b0;
                    match_cnt_q <= '0;
                end
            endcase

            // A clear wins over history but not over an error in the same cycle.
            if (bus.clr_err) begin
                err_count_q <= err_inc ? ERR_W'(1) : '0;
            end else if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_sync_count_checker.sv
module tb_sync_count_checker;

    localparam int WIDTH  = 4;
    localparam int LOCK_N = 3;
    localparam int ERR_W  = 2;

    logic clk;
    logic reset;

    sync_count_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    sync_count_checker #(
        .WIDTH (WIDTH),
        .LOCK_N(LOCK_N),
        .ERR_W (ERR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] q;
        logic             clr;
        logic [1:0]       st;
        logic             lk;
        logic             ep;
        logic             wp;
        logic [ERR_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input int q, input logic clr, input int st,
                       input logic lk, input logic ep, input logic wp, input int cnt);
        vec_t r;
        r.v = v; r.q = WIDTH'(q); r.clr = clr; r.st = 2'(st);
        r.lk = lk; r.ep = ep; r.wp = wp; r.cnt = ERR_W'(cnt);
        vecs.push_back(r);
    endtask

    // Drive after an edge, clock once, sample 1 time unit after the edge.
    task automatic cyc(input logic v, input int q, input logic clr);
        bus.q_valid = v;
        bus.q_in    = WIDTH'(q);
        bus.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int lk,
                           input int ep, input int wp, input int cnt);
        chk({tag, ".state"},      int'(bus.state),      st);
        chk({tag, ".locked"},     int'(bus.locked),     lk);
        chk({tag, ".err_pulse"},  int'(bus.err_pulse),  ep);
        chk({tag, ".wrap_pulse"}, int'(bus.wrap_pulse), wp);
        chk({tag, ".err_count"},  int'(bus.err_count),  cnt);
    endtask

    initial begin
        bus.q_valid = 1'b0;
        bus.q_in    = '0;
        bus.clr_err = 1'b0;
        reset       = 1'b0;

        // clean start: 0,1,2,3 -> locked after 3
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 0, 1, 0, 0, 0, 0);
        add(1, 3, 0, 2, 1, 0, 0, 0);
        // run up to 13 while locked, then 14,15,0,1: single wrap pulse
        for (int i = 4; i <= 15; i++) add(1, i, 0, 2, 1, 0, 0, 0);
        add(1, 0, 0, 2, 1, 0, 1, 0);
        add(1, 1, 0, 2, 1, 0, 0, 0);
        // break: 2..5 good, 9 breaks, 10,11,12 relock
        for (int i = 2; i <= 5; i++) add(1, i, 0, 2, 1, 0, 0, 0);
        add(1, 9, 0, 1, 0, 1, 0, 1);
        add(1, 10, 0, 1, 0, 0, 0, 1);
        add(1, 11, 0, 1, 0, 0, 0, 1);
        add(1, 12, 0, 2, 1, 0, 0, 1);
        // locked through wrap up to 6
        add(1, 13, 0, 2, 1, 0, 0, 1);
        add(1, 14, 0, 2, 1, 0, 0, 1);
        add(1, 15, 0, 2, 1, 0, 0, 1);
        add(1, 0, 0, 2, 1, 0, 1, 1);
        for (int i = 1; i <= 6; i++) add(1, i, 0, 2, 1, 0, 0, 1);
        // gap of 5 invalid cycles with q_in wandering, then 7, then stall 7
        add(0, 3, 0, 2, 1, 0, 0, 1);
        add(0, 7, 0, 2, 1, 0, 0, 1);
        add(0, 0, 0, 2, 1, 0, 0, 1);
        add(0, 15, 0, 2, 1, 0, 0, 1);
        add(0, 9, 0, 2, 1, 0, 0, 1);
        add(1, 7, 0, 2, 1, 0, 0, 1);
        add(1, 7, 0, 1, 0, 1, 0, 2);
        // relock 8,9,10; break 3 (send 0) -> count 3
        add(1, 8, 0, 1, 0, 0, 0, 2);
        add(1, 9, 0, 1, 0, 0, 0, 2);
        add(1, 10, 0, 2, 1, 0, 0, 2);
        add(1, 0, 0, 1, 0, 1, 0, 3);
        // relock 1,2,3; break 4 (send 9) -> saturated at 3
        add(1, 1, 0, 1, 0, 0, 0, 3);
        add(1, 2, 0, 1, 0, 0, 0, 3);
        add(1, 3, 0, 2, 1, 0, 0, 3);
        add(1, 9, 0, 1, 0, 1, 0, 3);
        // relock 10,11,12; break 5 (send 2) -> still 3
        add(1, 10, 0, 1, 0, 0, 0, 3);
        add(1, 11, 0, 1, 0, 0, 0, 3);
        add(1, 12, 0, 2, 1, 0, 0, 3);
        add(1, 2, 0, 1, 0, 1, 0, 3);
        // relock 3,4,5; break 6 with clr_err -> 1
        add(1, 3, 0, 1, 0, 0, 0, 3);
        add(1, 4, 0, 1, 0, 0, 0, 3);
        add(1, 5, 0, 2, 1, 0, 0, 3);
        add(1, 15, 1, 1, 0, 1, 0, 1);
        // relock across a wrap in SYNC (no wrap pulse), then clr alone -> 0
        add(1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 0, 0, 1);
        add(1, 2, 0, 2, 1, 0, 0, 1);
        add(0, 5, 1, 2, 1, 0, 0, 0);
        add(1, 3, 0, 2, 1, 0, 0, 0);
        // break with count 1 right before the async reset below
        add(1, 7, 0, 1, 0, 1, 0, 1);

        // reset state
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_release", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].v, int'(vecs[i].q), vecs[i].clr);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].lk),
                    int'(vecs[i].ep), int'(vecs[i].wp), int'(vecs[i].cnt));
        end

        // async reset mid-cycle: outputs clear without a clock edge
        bus.q_valid = 1'b1;
        bus.q_in    = 4'd8;
        #2 reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #3 reset = 1'b1;
        bus.q_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("idle_hold", 0, 0, 0, 0, 0);
        // history discarded: 8 becomes the new base, 9,10,11 lock
        cyc(1, 8, 0);
        chk_all("rst_seq8", 1, 0, 0, 0, 0);
        cyc(1, 9, 0);
        chk_all("rst_seq9", 1, 0, 0, 0, 0);
        cyc(1, 10, 0);
        chk_all("rst_seq10", 1, 0, 0, 0, 0);
        cyc(1, 11, 0);
        chk_all("rst_seq11", 2, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_count_checker.md
Name: sync_count_checker

Overview:
- Consumer-side monitor for a WIDTH-bit synchronous up-counter: samples the counter output on a strobe and confirms each sample equals the previous sample plus one, modulo 2^WIDTH.
- Locks after LOCK_N consecutive correct steps, then flags every sequence break and every wrap-around.
- Keeps a saturating error count.
- Sits beside the counter on the FPGA lab board; its outputs drive LEDs or a bench scoreboard.

Parameters:
WIDTH, 4, bit width of the monitored count
LOCK_N, 3, consecutive correct increments required to lock (must be >= 1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
q_in  input  WIDTH  counter value under check
q_valid  input  1  q_in sampled on this cycle when high
clr_err  input  1  synchronous clear of err_count
locked  output  1  high while sequence is tracked and correct
err_pulse  output  1  one-cycle pulse on sequence break while locked
wrap_pulse  output  1  one-cycle pulse on a correct max->0 step while locked
err_count  output  ERR_W  saturating count of err_pulse events
state  output  2  current FSM state (00 IDLE, 01 SYNC, 10 LOCKED)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, expected=0, match_cnt=0.
  - locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
  - Reset asserted mid-sequence discards all history.
- Register and latency rules:
  - All outputs are registered and reflect the sample taken on the previous rising edge with q_valid=1.
  - "Match" means q_in == expected. expected always loads (q_in + 1) mod 2^WIDTH on every valid sample, in every state.
  - q_valid=0: state, expected, match_cnt, locked and err_count hold. err_pulse and wrap_pulse are 0 the next cycle, except that err_count still obeys clr_err.
- IDLE: the first valid sample loads expected and moves the FSM to SYNC with match_cnt=0. No pulses.
- SYNC:
  - On match, match_cnt increments. If the incremented value equals LOCK_N, the FSM goes to LOCKED, locked=1 next cycle and match_cnt is cleared.
  - On mismatch, match_cnt=0 and the FSM stays in SYNC. No err_pulse, no err_count change.
  - Wraps in SYNC do not produce wrap_pulse.
- LOCKED:
  - On match, the FSM stays. If q_in==0 (step from 2^WIDTH-1 to 0), wrap_pulse=1 for one cycle.
  - On mismatch: err_pulse=1 for one cycle; err_count increments, saturating at 2^ERR_W-1; locked=0; the FSM goes to SYNC with match_cnt=0. The mismatching sample becomes the new base.
  - A repeated value (stalled counter) is a mismatch.
- clr_err: clears err_count next cycle. If it coincides with an error increment, err_count=1.
- err_count is not cleared by losing lock; only reset or clr_err clears it.
- The state encoding value 11 is unreachable. If it is ever entered, the FSM recovers to IDLE on the next edge.
- An implementation is 120-400 lines of RTL.

Test Plan:
- Reset then a clean sequence (WIDTH=4, LOCK_N=3): valid samples 0,1,2,3 each cycle -> state IDLE->SYNC; locked=1 the cycle after sample 3; err_count=0.
- Wrap: locked, samples 14,15,0,1 -> wrap_pulse=1 for exactly one cycle, after sample 0; locked stays 1; err_pulse never 1.
- Break while locked: samples 4,5,9,10,11,12 -> err_pulse=1 one cycle after 9; locked=0; err_count=1; relock the cycle after 12 (matches 10,11,12).
- Gaps and stall: locked at 6, then q_valid=0 for 5 cycles with q_in changing freely, then valid 7 -> no error, locked held. A later valid repeat 7,7 -> err_pulse, err_count increments.
- Saturation and clear (ERR_W=2): force 5 breaks while locked -> err_count sticks at 3. clr_err together with the 6th break -> err_count=1. clr_err alone -> 0.
- Async reset mid-lock: pull reset low between clock edges -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge. After release, a sample of 8 -> state SYNC.
